rmt_recovery_sequencer: RTL and testbench

Sequences register-map-table recovery after a misprediction or exception squash.
- Picks the nearest valid checkpoint copy for a single-cycle restore, or falls back to a pure ROB walk when no usable checkpoint exists.
- Walks squashed ROB entries youngest-to-oldest, two per cycle, driving the map table's recovery_map_* undo port with stale mappings.
- Sits between ROB/commit (squash request, ROB read port) and the rename stage's map table; stalls rename while busy.

---
 rtl/rmt_recovery_sequencer_pkg.sv | 24 ++
 rtl/rmt_recovery_sequencer_if.sv | 65 ++++++
 rtl/rmt_recovery_sequencer.sv | 138 +++++++++++++
 tb/tb_rmt_recovery_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rmt_recovery_sequencer_pkg.sv
// Shared types for register-map-table recovery sequencing.
// ROB tag, architectural/physical specifiers and sequencer state encoding.
package rmt_recovery_sequencer_pkg;

  localparam int ROB_DEPTH   = 64;
  localparam int CKPT_STRIDE = 8;
  localparam int NUM_CKPT    = ROB_DEPTH / CKPT_STRIDE;
  localparam int ROB_TAG_W   = $clog2(ROB_DEPTH);
  localparam int CKPT_OFS_W  = $clog2(CKPT_STRIDE);
  localparam int ARF_W       = 5;
  localparam int PRF_W       = 7;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [ARF_W-1:0]     arf_specifier_t;
  typedef logic [PRF_W-1:0]     prf_specifier_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_WALK    = 2'd2,
    ST_DONE    = 2'd3
  } rmt_rec_state_t;

endpackage

// File: rtl/rmt_recovery_sequencer_if.sv
// Bus between ROB/commit, the recovery sequencer and the rename map table.
// master: sequencer side; slave: ROB + map table + rename side.
interface rmt_recovery_sequencer_if
  import rmt_recovery_sequencer_pkg::*;
();

  logic           recovery_req;
  rob_tag_t       recovery_first_tag;
  rob_tag_t       rob_tail_tag;

  rob_tag_t       rob_rd_tag_0;
  rob_tag_t       rob_rd_tag_1;
  arf_specifier_t rob_rd_arf_0;
  arf_specifier_t rob_rd_arf_1;
  prf_specifier_t rob_rd_stale_prf_0;
  prf_specifier_t rob_rd_stale_prf_1;
  logic           rob_rd_has_rd_0;
  logic           rob_rd_has_rd_1;

  logic           recovery_mode;
  arf_specifier_t recovery_map_arf_0;
  arf_specifier_t recovery_map_arf_1;
  prf_specifier_t recovery_map_prf_0;
  prf_specifier_t recovery_map_prf_1;
  logic           recovery_map_0_valid;
  logic           recovery_map_1_valid;

  logic           recovery_flush;
  logic           recovery_no_copy;
  rob_tag_t       recovery_target_rob_tag;
  logic           rename_stall;
  logic           recovery_busy;
  logic           recovery_done;

  modport master (
    input  recovery_req, recovery_first_tag, rob_tail_tag,
    output rob_rd_tag_0, rob_rd_tag_1,
    input  rob_rd_arf_0, rob_rd_arf_1,
    input  rob_rd_stale_prf_0, rob_rd_stale_prf_1,
    input  rob_rd_has_rd_0, rob_rd_has_rd_1,
    output recovery_mode,
    output recovery_map_arf_0, recovery_map_arf_1,
    output recovery_map_prf_0, recovery_map_prf_1,
    output recovery_map_0_valid, recovery_map_1_valid,
    output recovery_flush, recovery_no_copy,
    output recovery_target_rob_tag,
    output rename_stall, recovery_busy, recovery_done
  );

  modport slave (
    output recovery_req, recovery_first_tag, rob_tail_tag,
    input  rob_rd_tag_0, rob_rd_tag_1,
    output rob_rd_arf_0, rob_rd_arf_1,
    output rob_rd_stale_prf_0, rob_rd_stale_prf_1,
    output rob_rd_has_rd_0, rob_rd_has_rd_1,
    input  recovery_mode,
    input  recovery_map_arf_0, recovery_map_arf_1,
    input  recovery_map_prf_0, recovery_map_prf_1,
    input  recovery_map_0_valid, recovery_map_1_valid,
    input  recovery_flush, recovery_no_copy,
    input  recovery_target_rob_tag,
    input  rename_stall, recovery_busy, recovery_done
  );

endinterface

// File: rtl/rmt_recovery_sequencer.sv
// Map-table recovery sequencer: checkpoint restore and/or two-wide ROB undo walk.
// Ports: clk, rst (async active-high), bus (master modport of the recovery bus).
module rmt_recovery_sequencer
  import rmt_recovery_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  rmt_recovery_sequencer_if.master    bus
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] RESTORE = ST_RESTORE;
  localparam logic [1:0] WALK    = ST_WALK;
  localparam logic [1:0] DONE    = ST_DONE;

  // Nearest checkpoint boundary at or after f; a copy is taken before
  // every entry whose low offset bits are zero.
  function automatic rob_tag_t ckpt_tag(rob_tag_t f);
    logic [ROB_TAG_W-CKPT_OFS_W-1:0] blk;
    blk = f[ROB_TAG_W-1:CKPT_OFS_W]
        + {{(ROB_TAG_W-CKPT_OFS_W-1){1'b0}}, |f[CKPT_OFS_W-1:0]};
    return {blk, {CKPT_OFS_W{1'b0}}};
  endfunction

  logic [1:0] state_q, state_d;
  rob_tag_t   f_q, f_d;
  rob_tag_t   tail_q, tail_d;
  rob_tag_t   cursor_q, cursor_d;
  logic       no_copy_q, no_copy_d;

  rob_tag_t   c_tag;
  rob_tag_t   dc;
  rob_tag_t   dt;
  rob_tag_t   rem;
  logic       busy;
  logic       walking;
  logic       pair;
  logic       v0;
  logic       v1;

  assign c_tag = ckpt_tag(bus.recovery_first_tag);
  assign dc    = c_tag - bus.recovery_first_tag;
  assign dt    = bus.rob_tail_tag - bus.recovery_first_tag;
  assign rem   = cursor_q - f_q;

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    tail_d    = tail_q;
    cursor_d  = cursor_q;
    no_copy_d = no_copy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.recovery_req) begin
          f_d    = bus.recovery_first_tag;
          tail_d = bus.rob_tail_tag;
          if (dt == '0) begin
            no_copy_d = 1'b0;
            state_d   = DONE;
          end else if (dc < dt) begin
            no_copy_d = 1'b0;
            cursor_d  = c_tag;
            state_d   = RESTORE;
          end else begin
            no_copy_d = 1'b1;
            cursor_d  = bus.rob_tail_tag;
            state_d   = WALK;
          end
        end
      end
      RESTORE: begin
        state_d = (cursor_q != f_q) ? WALK : DONE;
      end
      WALK: begin
        cursor_d = (rem >= rob_tag_t'(2))
                 ? cursor_q - rob_tag_t'(2)
                 : cursor_q - rob_tag_t'(1);
        if (rem <= rob_tag_t'(2)) state_d = DONE;
      end
      DONE: begin
        no_copy_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      f_q       <= '0;
      tail_q    <= '0;
      cursor_q  <= '0;
      no_copy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_q       <= f_d;
      tail_q    <= tail_d;
      cursor_q  <= cursor_d;
      no_copy_q <= no_copy_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign walking = (state_q == WALK);
  assign pair    = walking && (rem >= rob_tag_t'(2));

  // Slot0 is always the older entry; with one entry left only slot0 is used.
  always_comb begin
    bus.rob_rd_tag_0 = '0;
    bus.rob_rd_tag_1 = '0;
    if (pair) begin
      bus.rob_rd_tag_0 = cursor_q - rob_tag_t'(2);
      bus.rob_rd_tag_1 = cursor_q - rob_tag_t'(1);
    end else if (walking) begin
      bus.rob_rd_tag_0 = cursor_q - rob_tag_t'(1);
    end
  end

  assign v0 = walking && bus.rob_rd_has_rd_0 && (bus.rob_rd_arf_0 != '0);
  assign v1 = pair && bus.rob_rd_has_rd_1 && (bus.rob_rd_arf_1 != '0);

  assign bus.recovery_map_0_valid = v0;
  assign bus.recovery_map_1_valid = v1;
  assign bus.recovery_map_arf_0   = v0 ? bus.rob_rd_arf_0 : '0;
  assign bus.recovery_map_arf_1   = v1 ? bus.rob_rd_arf_1 : '0;
  assign bus.recovery_map_prf_0   = v0 ? bus.rob_rd_stale_prf_0 : '0;
  assign bus.recovery_map_prf_1   = v1 ? bus.rob_rd_stale_prf_1 : '0;

  assign bus.recovery_mode           = walking;
  assign bus.recovery_flush          = (state_q == RESTORE);
  assign bus.recovery_done           = (state_q == DONE);
  assign bus.recovery_busy           = busy;
  assign bus.rename_stall            = bus.recovery_req | busy;
  assign bus.recovery_no_copy        = busy & no_copy_q;
  assign bus.recovery_target_rob_tag = busy ? f_q : '0;

endmodule

// File: tb/tb_rmt_recovery_sequencer.sv
// Directed scoreboard bench for the map-table recovery sequencer.
// Expected per-cycle outputs are queued at stimulus time and popped each cycle.
module tb_rmt_recovery_sequencer;
  import rmt_recovery_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rmt_recovery_sequencer_if bus();

  rmt_recovery_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [ARF_W-1:0] arf_m [ROB_DEPTH];
  logic [PRF_W-1:0] prf_m [ROB_DEPTH];
  logic             has_m [ROB_DEPTH];

  assign bus.rob_rd_arf_0       = arf_m[bus.rob_rd_tag_0];
  assign bus.rob_rd_arf_1       = arf_m[bus.rob_rd_tag_1];
  assign bus.rob_rd_stale_prf_0 = prf_m[bus.rob_rd_tag_0];
  assign bus.rob_rd_stale_prf_1 = prf_m[bus.rob_rd_tag_1];
  assign bus.rob_rd_has_rd_0    = has_m[bus.rob_rd_tag_0];
  assign bus.rob_rd_has_rd_1    = has_m[bus.rob_rd_tag_1];

  // ctl = {stall, busy, flush, mode, done, no_copy}
  typedef struct packed {
    logic [5:0]  ctl;
    rob_tag_t    tgt;
    logic [37:0] s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic logic [37:0] slots(rob_tag_t t0, rob_tag_t t1,
                                        bit two);
    logic v0, v1;
    rob_tag_t t1o;
    v0  = has_m[t0] && (arf_m[t0] != '0);
    v1  = two && has_m[t1] && (arf_m[t1] != '0);
    t1o = two ? t1 : '0;
    return {t0, t1o, v0, v1,
            v0 ? arf_m[t0] : 5'd0, v1 ? arf_m[t1] : 5'd0,
            v0 ? prf_m[t0] : 7'd0, v1 ? prf_m[t1] : 7'd0};
  endfunction

  task automatic px(logic [5:0] ctl, rob_tag_t tgt, logic [37:0] s);
    exp_t e;
    e.ctl = ctl;
    e.tgt = tgt;
    e.s   = s;
    sb.push_back(e);
  endtask

  task automatic chk(exp_t e, string tag);
    exp_t o;
    o.ctl = {bus.rename_stall, bus.recovery_busy, bus.recovery_flush,
             bus.recovery_mode, bus.recovery_done, bus.recovery_no_copy};
    o.tgt = bus.recovery_target_rob_tag;
    o.s   = {bus.rob_rd_tag_0, bus.rob_rd_tag_1,
             bus.recovery_map_0_valid, bus.recovery_map_1_valid,
             bus.recovery_map_arf_0, bus.recovery_map_arf_1,
             bus.recovery_map_prf_0, bus.recovery_map_prf_1};
    checks++;
    assert (o.ctl === e.ctl) else begin
      fails++;
      $error("FAIL %s ctl obs=%b exp=%b", tag, o.ctl, e.ctl);
    end
    checks++;
    assert (o.tgt === e.tgt) else begin
      fails++;
      $error("FAIL %s tgt obs=%h exp=%h", tag, o.tgt, e.tgt);
    end
    checks++;
    assert (o.s === e.s) else begin
      fails++;
      $error("FAIL %s slots obs=%h exp=%h", tag, o.s, e.s);
    end
  endtask

  // Entered at posedge+1; one queued record is checked per cycle.
  task automatic run(string name, rob_tag_t f, rob_tag_t t, int rereq);
    int cyc = 0;
    bus.recovery_first_tag = f;
    bus.rob_tail_tag       = t;
    bus.recovery_req       = 1'b1;
    while (sb.size() > 0 && cyc < 40) begin
      @(negedge clk);
      chk(sb.pop_front(), $sformatf("%s_c%0d", name, cyc));
      @(posedge clk);
      #1;
      cyc++;
      bus.recovery_req = (cyc == rereq);
      if (cyc == rereq) bus.recovery_first_tag = 6'h05;
    end
    checks++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s timeout left=%0d exp=0", name, sb.size());
      sb.delete();
    end
  endtask

  localparam logic [5:0] C_REQ  = 6'b100000;
  localparam logic [5:0] C_RST  = 6'b111000;
  localparam logic [5:0] C_WLK  = 6'b110100;
  localparam logic [5:0] C_WLKN = 6'b110101;
  localparam logic [5:0] C_DN   = 6'b110010;
  localparam logic [5:0] C_DNN  = 6'b110011;
  localparam logic [5:0] C_IDL  = 6'b000000;

  initial begin
    exp_t z;
    z = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      arf_m[i] = ARF_W'((i % 31) + 1);
      prf_m[i] = PRF_W'(i + 64);
      has_m[i] = 1'b1;
    end
    bus.recovery_req       = 1'b0;
    bus.recovery_first_tag = '0;
    bus.rob_tail_tag       = '0;

    #2;
    chk(z, "reset");
    bus.recovery_req = 1'b1;
    #1;
    px(C_REQ, '0, '0);
    chk(sb.pop_front(), "reset_stall");
    bus.recovery_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: checkpoint restore then partial walk
    px(C_REQ, 6'h00, '0);
    px(C_RST, 6'h0B, '0);
    px(C_WLK, 6'h0B, slots(6'h0E, 6'h0F, 1));
    px(C_WLK, 6'h0B, slots(6'h0C, 6'h0D, 1));
    px(C_WLK, 6'h0B, slots(6'h0B, 6'h00, 0));
    px(C_DN,  6'h0B, '0);
    px(C_IDL, 6'h00, '0);
    run("t1", 6'h0B, 6'h15, -1);

    // 2: checkpoint not yet allocated, walk from tail
    px(C_REQ,  6'h00, '0);
    px(C_WLKN, 6'h0B, slots(6'h0C, 6'h0D, 1));
    px(C_WLKN, 6'h0B, slots(6'h0B, 6'h00, 0));
    px(C_DNN,  6'h0B, '0);
    px(C_IDL,  6'h00, '0);
    run("t2", 6'h0B, 6'h0E, -1);

    // 3a: f on a checkpoint boundary, restore only
    px(C_REQ, 6'h00, '0);
    px(C_RST, 6'h10, '0);
    px(C_DN,  6'h10, '0);
    px(C_IDL, 6'h00, '0);
    run("t3a", 6'h10, 6'h14, -1);

    // 3b: empty squash
    px(C_REQ, 6'h00, '0);
    px(C_DN,  6'h10, '0);
    px(C_IDL, 6'h00, '0);
    run("t3b", 6'h10, 6'h10, -1);

    // 4: checkpoint wraps to tag 0
    px(C_REQ, 6'h00, '0);
    px(C_RST, 6'h3D, '0);
    px(C_WLK, 6'h3D, slots(6'h3E, 6'h3F, 1));
    px(C_WLK, 6'h3D, slots(6'h3D, 6'h00, 0));
    px(C_DN,  6'h3D, '0);
    px(C_IDL, 6'h00, '0);
    run("t4", 6'h3D, 6'h03, -1);

    // 5: no-destination entries and a same-arf pair
    has_m[6'h23] = 1'b0;
    arf_m[6'h24] = 5'd0;
    arf_m[6'h21] = 5'd5;
    arf_m[6'h22] = 5'd5;
    px(C_REQ,  6'h00, '0);
    px(C_WLKN, 6'h21, slots(6'h23, 6'h24, 1));
    px(C_WLKN, 6'h21, {6'h21, 6'h22, 1'b1, 1'b1, 5'd5, 5'd5,
                       7'h61, 7'h62});
    px(C_DNN,  6'h21, '0);
    px(C_IDL,  6'h00, '0);
    run("t5", 6'h21, 6'h25, -1);

    // 6: second request while busy is ignored, then reset mid-walk
    px(C_REQ,  6'h00, '0);
    px(C_WLKN, 6'h31, slots(6'h35, 6'h36, 1));
    px(C_WLKN, 6'h31, slots(6'h33, 6'h34, 1));
    run("t6", 6'h31, 6'h37, 1);
    #2;
    rst = 1'b1;
    #1;
    chk(z, "t6_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(z, $sformatf("t6_post%0d", i));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
